// File: rtl/uncache_data_unit_if.sv
// Mem-stage request/response signals and the single-beat bus used by the uncached data path.
// Handshakes: a request holds its fields stable until accepted (req_valid/addr_ok, rd_req/rd_rdy, wr_req/wr_rdy); data_ok, ret_valid and wr_done are one-cycle pulses.
interface uncache_data_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_paddr;
    logic [3:0]            req_wstrb;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  flush;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;

    logic                  rd_req;
    logic [1:0]            rd_size;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_rdy;
    logic                  ret_valid;
    logic [DATA_WIDTH-1:0] ret_data;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [1:0]            wr_size;
    logic [3:0]            wr_strb;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_rdy;
    logic                  wr_done;

    modport slave (
        input  req_valid, req_we, req_size, req_paddr, req_wstrb, req_wdata, flush,
        output addr_ok, data_ok, rdata, busy,
        output rd_req, rd_size, rd_addr,
        input  rd_rdy, ret_valid, ret_data,
        output wr_req, wr_addr, wr_size, wr_strb, wr_data,
        input  wr_rdy, wr_done
    );

    modport master (
        output req_valid, req_we, req_size, req_paddr, req_wstrb, req_wdata, flush,
        input  addr_ok, data_ok, rdata, busy,
        input  rd_req, rd_size, rd_addr,
        output rd_rdy, ret_valid, ret_data,
        input  wr_req, wr_addr, wr_size, wr_strb, wr_data,
        output wr_rdy, wr_done
    );
endinterface

// File: rtl/uncache_data_unit.sv
// Uncached load/store responder: one mem-stage request at a time, run as a single-beat bus
// transaction, answered with a data_ok pulse. o_state exposes the FSM (IDLE reads as 0).
module uncache_data_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    uncache_data_unit_if.slave  io_bus,
    output logic [2:0]          o_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_drop;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_strb;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_accept;

    assign w_accept = (r_state == S_IDLE) && io_bus.req_valid && !io_bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_strb  <= '0;
            r_data  <= '0;
            r_rdata <= '0;
        end else begin
            // A flush never aborts the bus side; it only marks the response for discard.
            if (io_bus.flush && (r_state != S_IDLE)) begin
                r_drop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_size  <= io_bus.req_size;
                        r_addr  <= io_bus.req_paddr;
                        r_strb  <= io_bus.req_wstrb;
                        r_data  <= io_bus.req_wdata;
                        r_state <= io_bus.req_we ? S_WR_REQ : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (io_bus.rd_rdy) r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (io_bus.ret_valid) begin
                        r_rdata <= io_bus.ret_data;
                        r_state <= S_RESP;
                    end
                end
                S_WR_REQ: begin
                    if (io_bus.wr_rdy) r_state <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (io_bus.wr_done) begin
                        r_rdata <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_drop  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.addr_ok = w_accept;
    assign io_bus.data_ok = (r_state == S_RESP) && !r_drop && !io_bus.flush;
    assign io_bus.rdata   = r_rdata;
    assign io_bus.busy    = (r_state != S_IDLE);
    assign io_bus.rd_req  = (r_state == S_RD_REQ);
    assign io_bus.rd_size = r_size;
    assign io_bus.rd_addr = r_addr;
    assign io_bus.wr_req  = (r_state == S_WR_REQ);
    assign io_bus.wr_addr = r_addr;
    assign io_bus.wr_size = r_size;
    assign io_bus.wr_strb = r_strb;
    assign io_bus.wr_data = r_data;
    assign o_state        = r_state;
endmodule
